// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and default width shared by the serial ALU.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam int ALU_WIDTH = 16;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ALU1Bit.sv
// ALU1Bit: combinational 1-bit ALU slice; Bnegate inverts B ahead of every op.
module ALU1Bit
  import alu_pkg::*;
(
  input  logic       A,
  input  logic       B,
  input  logic       Bnegate,
  input  logic       CIN,
  input  logic [2:0] operation,
  output logic       Result,
  output logic       cout
);
  logic bb;
  assign bb = B ^ Bnegate;
  always_comb begin
    Result = operation == OP_AND ? (A & bb) :
             operation == OP_OR  ? (A | bb) :
             operation == OP_XOR ? (A ^ bb) :
             operation == OP_ADD ? (A ^ bb ^ CIN) : 1'b0;
    cout = (A & bb) | (A & CIN) | (bb & CIN);
  end
endmodule

// File: rtl/alu_serial16.sv
// alu_serial16: bit-serial ALU sequencer feeding one operand bit pair per clock, LSB first, into ALU1Bit.
module alu_serial16
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       operation,
  input  logic             bnegate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  state_t state;
  logic [WIDTH-1:0] a_reg, b_reg, res_next;
  logic [2:0] op_reg;
  logic neg_reg, carry, bit_res, bit_cout, c_next;
  logic [CNT_W-1:0] cnt;
  ALU1Bit u_slice (
    .A(a_reg[0]),
    .B(b_reg[0]),
    .Bnegate(neg_reg),
    .CIN(carry),
    .operation(op_reg),
    .Result(bit_res),
    .cout(bit_cout)
  );
  // carry only chains for ADD; logic ops never see a carry
  assign c_next = (op_reg == OP_ADD) & bit_cout;
  assign res_next = {bit_res, result[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
      cnt <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      op_reg <= '0;
      neg_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            op_reg <= operation;
            neg_reg <= bnegate;
            carry <= bnegate;
            cnt <= '0;
            busy <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          result <= res_next;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          carry <= c_next;
          cnt <= cnt + CNT_W'(1);
          // carry still holds the carry into the MSB on the last bit
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
            cout <= c_next;
            overflow <= carry ^ c_next;
            zero <= res_next == '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial16.sv
// tb_alu_serial16: table-driven and randomized checks of alu_serial16 against an arithmetic model.
module tb_alu_serial16;
  import alu_pkg::*;
  logic clk = 0, reset = 1, start = 0, bnegate = 0;
  logic [15:0] a = 0, b = 0;
  logic [2:0] operation = 0;
  logic busy, done, cout, overflow, zero;
  logic [15:0] result;
  int n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic [15:0] a, b;
    logic [2:0] op;
    logic neg;
    logic [15:0] r;
    logic c, v, z;
  } vec_t;

  alu_serial16 dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .operation(operation),
    .bnegate(bnegate), .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [15:0] x, input logic [15:0] y, input logic [2:0] o, input logic n);
    vec_t m;
    logic [15:0] yy;
    logic [16:0] s;
    m = '0;
    m.a = x; m.b = y; m.op = o; m.neg = n;
    yy = n ? ~y : y;
    s = {1'b0, x} + {1'b0, yy} + 17'(n);
    case (o)
      3'b000: m.r = x & yy;
      3'b010: m.r = x | yy;
      3'b011: m.r = x ^ yy;
      3'b100: begin
        m.r = s[15:0];
        m.c = s[16];
        m.v = (x[15] == yy[15]) && (s[15] != x[15]);
      end
      default: m.r = '0;
    endcase
    m.z = m.r == 0;
    return m;
  endfunction

  task automatic do_op(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; operation = v.op; bnegate = v.neg; start = 1;
    @(negedge clk);
    start = 0;
    a = 16'($urandom); b = 16'($urandom); operation = 3'($urandom); bnegate = 1'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        start = 1; a = ~v.a; b = ~v.b;
      end else start = 0;
      @(negedge clk);
      lat++;
    end
    start = 0;
    chk({name, " latency"}, lat, 17);
    chk({name, " busy@done"}, busy, 0);
    chk({name, " result"}, result, v.r);
    chk({name, " cout"}, cout, v.c);
    chk({name, " overflow"}, overflow, v.v);
    chk({name, " zero"}, zero, v.z);
  endtask

  vec_t vecs[6];
  vec_t e;
  int done_at[$];
  logic [15:0] res_at[$];
  int pulses;

  initial begin
    vecs[0] = '{16'h7FFF, 16'h0001, 3'b100, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0005, 16'h0005, 3'b100, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'hF0F0, 16'hFF00, 3'b000, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'hF0F0, 16'hFF00, 3'b010, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'hAAAA, 16'hFFFF, 3'b011, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 3'b111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset flags", {cout, overflow, zero}, 0);
    for (int i = 0; i < 6; i++) do_op(vecs[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 30; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      e = model(16'($urandom), 16'($urandom), o, (o == 3'b100) ? 1'($urandom) : 1'b0);
      do_op(e, $sformatf("rand%0d", i));
    end
    // start held high: one op per 17 cycles, operands changed while busy
    @(negedge clk);
    a = 16'd1; b = 16'd1; operation = 3'b100; bnegate = 0; start = 1;
    @(negedge clk);
    a = 16'd5; b = 16'd5;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        done_at.push_back(k);
        res_at.push_back(result);
      end
      @(negedge clk);
    end
    start = 0;
    repeat (20) @(negedge clk);
    chk("hs pulses", done_at.size(), 2);
    if (done_at.size() == 2) begin
      chk("hs first done", done_at[0], 17);
      chk("hs period", done_at[1] - done_at[0], 17);
      chk("hs first result", res_at[0], 16'h0002);
      chk("hs second result", res_at[1], 16'h000A);
    end
    // reset in the middle of an operation
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; operation = 3'b100; bnegate = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    chk("midreset busy before", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midreset busy", busy, 0);
    chk("midreset result", result, 0);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("midreset no done", pulses, 0);
    do_op(model(16'h0003, 16'h0001, 3'b100, 1'b1), "post reset sub");
    // reset and start together: reset wins
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; operation = 3'b100; start = 1; reset = 1;
    @(negedge clk);
    start = 0; reset = 0;
    chk("reset vs start busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
